// File: rtl/mdu_if.sv
// Operand/result bundle between the execute stage and the multiply/divide unit.
// Signals: start/MDUOp/ScrA/ScrB are the request; busy/done/HI/LO are the
// registered results. The master modport drives requests and the slave modport is the MDU.
interface mdu_if;
    logic        start;
    logic [2:0]  MDUOp;
    logic [31:0] ScrA;
    logic [31:0] ScrB;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, MDUOp, ScrA, ScrB,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, MDUOp, ScrA, ScrB,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Latency: MULT_CYCLES or DIV_CYCLES edges from start to the HI/LO commit. mthi/mtlo take one edge.
// Backpressure: busy is held for the full operation, and any start seen while busy is dropped.
// Ports: clk, reset (synchronous, active-low), bus (mdu_if.slave: start, MDUOp, ScrA, ScrB -> busy, done, HI, LO).
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic   clk,
    input  logic   reset,
    mdu_if.slave   bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [63:0]     pend_res;   // {HI, LO} to commit when the count expires
    logic            pend_dz;    // divide by zero: run the full sequence but commit nothing
    logic            busy_q;
    logic            done_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;

    // ------------------------------------------------------------------
    // Operation decode
    // ------------------------------------------------------------------
    logic op_is_md;
    logic op_is_div;
    logic op_is_signed;

    assign op_is_md     = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU) ||
                          (bus.MDUOp == OP_DIV)  || (bus.MDUOp == OP_DIVU);
    assign op_is_div    = (bus.MDUOp == OP_DIV) || (bus.MDUOp == OP_DIVU);
    assign op_is_signed = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_DIV);

    // ------------------------------------------------------------------
    // Multiply: a 64x64 product of the sign- or zero-extended operands
    // gives the correct low 64 bits for both the signed and unsigned forms.
    // ------------------------------------------------------------------
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] mul_res;

    assign a_ext   = {{32{op_is_signed & bus.ScrA[31]}}, bus.ScrA};
    assign b_ext   = {{32{op_is_signed & bus.ScrB[31]}}, bus.ScrB};
    assign mul_res = a_ext * b_ext;

    // ------------------------------------------------------------------
    // Divide on magnitudes, then reapply signs. The quotient is negative when
    // the operand signs differ, and the remainder takes the dividend's sign.
    // 0x80000000 / -1 needs no special case: the magnitude quotient is
    // 0x80000000 with a positive sign, which is the required wrapped result.
    // ------------------------------------------------------------------
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_zero;

    assign a_neg    = op_is_signed & bus.ScrA[31];
    assign b_neg    = op_is_signed & bus.ScrB[31];
    assign a_mag    = a_neg ? (32'd0 - bus.ScrA) : bus.ScrA;
    assign b_mag    = b_neg ? (32'd0 - bus.ScrB) : bus.ScrB;
    assign div_zero = (bus.ScrB == 32'd0);
    // A zero divisor is swapped for 1 so the divider never produces X.
    // That result is discarded through pend_dz anyway.
    assign b_safe   = div_zero ? 32'd1 : b_mag;
    assign q_mag    = a_mag / b_safe;
    assign r_mag    = a_mag % b_safe;
    assign quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

    logic [63:0] op_res;
    logic [CW-1:0] op_cycles;

    assign op_res    = op_is_div ? {rem, quot} : mul_res;
    assign op_cycles = op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);

    // ------------------------------------------------------------------
    // Control FSM. All outputs are registered here.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pend_res <= '0;
            pend_dz  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (op_is_md) begin
                            pend_res <= op_res;
                            pend_dz  <= op_is_div & div_zero;
                            cnt      <= op_cycles;
                            busy_q   <= 1'b1;
                            state    <= RUN;
                        end else if (bus.MDUOp == OP_MTHI) begin
                            hi_q <= bus.ScrA;
                        end else if (bus.MDUOp == OP_MTLO) begin
                            lo_q <= bus.ScrA;
                        end
                    end
                end
                RUN: begin
                    // Requests arriving here are dropped. The hazard unit stalls on busy.
                    if (cnt == CW'(1)) begin
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                        if (!pend_dz) begin
                            hi_q <= pend_res[63:32];
                            lo_q <= pend_res[31:0];
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    cnt    <= '0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Randomized self-checking bench for mdu against a longint arithmetic model.
module tb_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;
    mdu_if bus ();

    mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_hi = 32'd0;
    logic [31:0] exp_lo = 32'd0;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural values.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] cur_hi, input logic [31:0] cur_lo,
                                  output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = cur_hi;
        lo = cur_lo;
        case (op)
            3'd0: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            3'd2: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                p = 64'(q); lo = p[31:0];
                p = 64'(r); hi = p[31:0];
            end
            3'd3: if (b != 0) begin
                lo = a / b; hi = a % b;
            end
            3'd4: hi = a;
            3'd5: lo = a;
            default: ;
        endcase
    endfunction

    // Called at a negedge. Presents one request for a single edge and returns in the cycle after it.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        model(op, a, b, exp_hi, exp_lo, pend_hi, pend_lo);
        bus.start = 1'b1;
        bus.MDUOp = op;
        bus.ScrA  = a;
        bus.ScrB  = b;
        @(negedge clk);
        bus.start = 1'b0;
        if (op > 3'd3) begin
            exp_hi = pend_hi;
            exp_lo = pend_lo;
        end
    endtask

    // Counts busy cycles and checks the commit. Returns at the negedge of the done cycle.
    task automatic finish_op(input string tag, input int n, input int pre);
        int cnt;
        cnt = pre;
        while (bus.busy && cnt < n + 4) begin
            if (bus.HI !== exp_hi || bus.LO !== exp_lo)
                check({tag, "_hold"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
            if (bus.done !== 1'b0) check({tag, "_early_done"}, 64'(bus.done), 64'd0);
            cnt++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 64'(cnt), 64'(n));
        check({tag, "_done"}, 64'(bus.done), 64'd1);
        exp_hi = pend_hi;
        exp_lo = pend_lo;
        check({tag, "_hilo"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    task automatic run_md(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        finish_op(tag, (op >= 3'd2) ? DC : MC, 0);
        after_done(tag);
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] a);
        issue(op, a, 32'd0);
        check({tag, "_hilo"}, {bus.HI, bus.LO}, {exp_hi, exp_lo});
        check({tag, "_busy"}, {62'd0, bus.busy, bus.done}, 64'd0);
    endtask

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'(($urandom_range(0, 20)));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.MDUOp = 3'd0;
        bus.ScrA  = 32'd0;
        bus.ScrB  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("reset_state", {bus.HI, bus.LO, 28'd0, 2'd0, bus.busy, bus.done}, 96'd0);
        @(negedge clk);

        // Directed cases
        run_md("mult",  3'd0, 32'hFFFF_FFFE, 32'd3);
        check("mult_val", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_md("multu", 3'd1, 32'hFFFF_FFFE, 32'd3);
        check("multu_val", {bus.HI, bus.LO}, 64'h0000_0002_FFFF_FFFA);
        run_md("div",   3'd2, 32'hFFFF_FFF9, 32'd2);
        check("div_val", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_md("divu",  3'd3, 32'd7, 32'd2);
        check("divu_val", {bus.HI, bus.LO}, 64'h0000_0001_0000_0003);
        run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_val", {bus.HI, bus.LO}, 64'h0000_0000_8000_0000);

        run_mt("mthi", 3'd4, 32'h11);
        run_mt("mtlo", 3'd5, 32'h22);
        run_md("div0", 3'd2, 32'd1234, 32'd0);
        check("div0_val", {bus.HI, bus.LO}, 64'h0000_0011_0000_0022);
        run_md("divu0", 3'd3, 32'hFFFF_0000, 32'd0);
        run_mt("undef", 3'd6, 32'hDEAD_BEEF);

        // A start during RUN is dropped, even for mtlo.
        issue(3'd0, 32'd1000, 32'd3);
        @(negedge clk);
        bus.start = 1'b1; bus.MDUOp = 3'd5; bus.ScrA = 32'h55;
        @(negedge clk);
        bus.start = 1'b0;
        finish_op("ign", MC, 2);
        check("ign_val", {bus.HI, bus.LO}, 64'd3000);
        after_done("ign");

        // Back-to-back: issue a new op in the done cycle
        issue(3'd1, 32'd6, 32'd7);
        finish_op("b2b_a", MC, 0);
        issue(3'd3, 32'd100, 32'd7);
        finish_op("b2b_b", DC, 0);
        check("b2b_val", {bus.HI, bus.LO}, {32'd2, 32'd14});
        after_done("b2b");

        // Reset in the third busy cycle of a div
        issue(3'd2, 32'd50, 32'd3);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("rst_mid", {bus.HI, bus.LO, 30'd0, bus.busy, bus.done}, 96'd0);
        begin
            int seen = 0;
            for (int i = 0; i < DC + 2; i++) begin
                @(negedge clk);
                if (bus.done || bus.busy) seen++;
            end
            check("rst_no_done", 64'(seen), 64'd0);
        end

        // Reset wins over a coincident start
        run_mt("pre_rp", 3'd4, 32'h77);
        reset = 1'b0;
        bus.start = 1'b1; bus.MDUOp = 3'd0; bus.ScrA = 32'd9; bus.ScrB = 32'd9;
        @(negedge clk);
        reset = 1'b1;
        bus.start = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("rst_prio", {bus.HI, bus.LO, 30'd0, bus.busy, bus.done}, 96'd0);
        @(negedge clk);
        check("rst_prio_idle", 64'(bus.busy), 64'd0);

        // Randomized sequence
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = rand_opnd();
            b  = rand_opnd();
            if (op <= 3'd3) run_md($sformatf("rnd%0d_op%0d", i, op), op, a, b);
            else            run_mt($sformatf("rnd%0d_op%0d", i, op), op, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
